sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO; next generation of the fixed-geometry FIFO36K primitive. Generalises width and depth, adds a first-word-fall-through (FWFT) read mode and an occupancy count output. Sits between any two same-clock blocks that need elastic buffering with programmable watermarks.

---
 rtl/sync_fifo_prog.sv | 143 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with registered status flags, occupancy count,
// programmable watermarks and a selectable standard / first-word-fall-through read port.
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH        = 36,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned PROG_EMPTY_THRESH = 4,
  parameter int unsigned PROG_FULL_THRESH  = 1018,
  parameter int unsigned FWFT              = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH:0]   WORD_COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  PROG_EMPTY,
  output logic                  PROG_FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam cnt_t CntDepth   = cnt_t'(DEPTH);
  localparam cnt_t CntDepthM1 = cnt_t'(DEPTH - 1);
  localparam cnt_t CntOne     = cnt_t'(1);
  localparam cnt_t CntPe      = cnt_t'(PROG_EMPTY_THRESH);
  localparam cnt_t CntPf      = cnt_t'(PROG_FULL_THRESH);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_data_width
    $error("sync_fifo_prog: DATA_WIDTH must be 1..72");
  end
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_addr_width
    $error("sync_fifo_prog: ADDR_WIDTH must be 2..12");
  end
  if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pe
    $error("sync_fifo_prog: PROG_EMPTY_THRESH must be 1..DEPTH-1");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1) begin : g_bad_pf
    $error("sync_fifo_prog: PROG_FULL_THRESH must be 1..DEPTH-1");
  end
  if (FWFT > 1) begin : g_bad_fwft
    $error("sync_fifo_prog: FWFT must be 0 or 1");
  end

  data_t mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  logic empty_q, full_q, almost_empty_q, almost_full_q, prog_empty_q, prog_full_q;
  logic empty_d, full_d, almost_empty_d, almost_full_d, prog_empty_d, prog_full_d;
  logic overflow_q, underflow_q;
  logic wr_acc, rd_acc;

  // Acceptance uses only registered flags, so no request-to-flag combinational path exists.
  always_comb begin
    wr_acc   = WR_EN & ~full_q;
    rd_acc   = RD_EN & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    count_d        = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
    empty_d        = (count_d == '0);
    full_d         = (count_d == CntDepth);
    almost_empty_d = (count_d <= CntOne);
    almost_full_d  = (count_d >= CntDepthM1);
    prog_empty_d   = (count_d <= CntPe);
    prog_full_d    = (count_d >= CntPf);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      prog_empty_q   <= 1'b1;
      prog_full_q    <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      prog_empty_q   <= prog_empty_d;
      prog_full_q    <= prog_full_d;
      overflow_q     <= WR_EN & full_q;
      underflow_q    <= RD_EN & empty_q;
    end
  end

  // Storage is not reset; only the pointers define which words are valid.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RESET) begin
      mem[wr_ptr_q] <= WR_DATA;
    end
  end

  if (FWFT == 0) begin : g_std_read
    data_t rd_data_q;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        rd_data_q <= '0;
      end else if (rd_acc) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
    assign RD_DATA = rd_data_q;
  end else begin : g_fwft_read
    // Head word is always presented; its value is meaningless while EMPTY.
    assign RD_DATA = mem[rd_ptr_q];
  end

  assign WORD_COUNT   = count_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = almost_empty_q;
  assign ALMOST_FULL  = almost_full_q;
  assign PROG_EMPTY   = prog_empty_q;
  assign PROG_FULL    = prog_full_q;
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised self-checking bench: a standard-read and an FWFT instance share stimulus and
// are compared against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int PE = 4;
  localparam int PF = 14;

  logic clk;
  logic rst, wr_en, rd_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1;
  logic [AW:0] wc0, wc1;
  logic empty0, full0, ae0, af0, pe0, pf0, ovf0, unf0;
  logic empty1, full1, ae1, af1, pe1, pf1, ovf1, unf1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd0;
  bit m_ovf, m_unf;

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_EMPTY_THRESH(PE), .PROG_FULL_THRESH(PF), .FWFT(0)
  ) dut0 (
    .CLK(clk), .RESET(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_data0), .WORD_COUNT(wc0), .EMPTY(empty0), .FULL(full0),
    .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0), .PROG_EMPTY(pe0), .PROG_FULL(pf0),
    .OVERFLOW(ovf0), .UNDERFLOW(unf0)
  );

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_EMPTY_THRESH(PE), .PROG_FULL_THRESH(PF), .FWFT(1)
  ) dut1 (
    .CLK(clk), .RESET(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_data1), .WORD_COUNT(wc1), .EMPTY(empty1), .FULL(full1),
    .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .PROG_EMPTY(pe1), .PROG_FULL(pf1),
    .OVERFLOW(ovf1), .UNDERFLOW(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model advances from its pre-edge occupancy.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    bit was_full, was_empty;
    rst = r; wr_en = w; wr_data = d; rd_en = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rd0 = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_unf = rd && was_empty;
      if (rd && !was_empty) m_rd0 = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    rst = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    step(1, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    checks++;
    if ({empty0, full0, pe0, wc0} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_flags: got E=%b F=%b PE=%b cnt=%0d, want E=1 F=0 PE=1 cnt=0",
               empty0, full0, pe0, wc0);
    end
    checks++;
    if (rd_data0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data: got %h want 00", rd_data0);
    end
    step(0, 0, 0, 1);
    checks++;
    if (unf0 !== 1'b1 || wc0 !== 5'd0 || empty1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_nothing_stored: got UNF=%b cnt=%0d E1=%b want 1 0 1", unf0, wc0, empty1);
    end
  endtask

  task automatic test_fill();
    int n;
    step(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, DW'(i), 0);
      n = i + 1;
      checks++;
      if (wc0 !== 5'(n) || pf0 !== (n >= PF) || af0 !== (n >= DEPTH - 1) || full0 !== (n == DEPTH))
      begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d PF=%b AF=%b F=%b want cnt=%0d PF=%b AF=%b F=%b",
                 n, wc0, pf0, af0, full0, n, n >= PF, n >= DEPTH - 1, n == DEPTH);
      end
    end
    step(0, 1, 8'hEE, 0);
    checks++;
    if (ovf0 !== 1'b1 || wc0 !== 5'd16) begin
      errors++;
      $display("FAIL fill_overflow: got OVF=%b cnt=%0d want 1 16", ovf0, wc0);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ovf0 !== 1'b0 || wc0 !== 5'd16) begin
      errors++;
      $display("FAIL fill_overflow_pulse: got OVF=%b cnt=%0d want 0 16", ovf0, wc0);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data1 !== DW'(i)) begin
        errors++;
        $display("FAIL drain_fwft_head_%0d: got %h want %h", i, rd_data1, DW'(i));
      end
      step(0, 0, 0, 1);
      checks++;
      if (rd_data0 !== DW'(i)) begin
        errors++;
        $display("FAIL drain_std_%0d: got %h want %h", i, rd_data0, DW'(i));
      end
    end
    checks++;
    if (empty0 !== 1'b1 || ae0 !== 1'b1 || wc0 !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: got E=%b AE=%b cnt=%0d want 1 1 0", empty0, ae0, wc0);
    end
    step(0, 0, 0, 1);
    checks++;
    if (unf0 !== 1'b1 || rd_data0 !== 8'h0F) begin
      errors++;
      $display("FAIL drain_underflow: got UNF=%b rd=%h want 1 0f", unf0, rd_data0);
    end
    step(0, 0, 0, 0);
    checks++;
    if (unf0 !== 1'b0 || rd_data0 !== 8'h0F) begin
      errors++;
      $display("FAIL drain_underflow_pulse: got UNF=%b rd=%h want 0 0f", unf0, rd_data0);
    end
  endtask

  task automatic test_fwft();
    step(1, 0, 0, 0);
    step(0, 1, 8'hA5, 0);
    checks++;
    if (empty1 !== 1'b0 || rd_data1 !== 8'hA5 || rd_data0 !== 8'h00) begin
      errors++;
      $display("FAIL fwft_fallthrough: got E=%b rd1=%h rd0=%h want 0 a5 00",
               empty1, rd_data1, rd_data0);
    end
    step(0, 0, 0, 0);
    checks++;
    if (rd_data1 !== 8'hA5) begin
      errors++;
      $display("FAIL fwft_hold: got %h want a5", rd_data1);
    end
    step(0, 0, 0, 1);
    checks++;
    if (empty1 !== 1'b1 || rd_data0 !== 8'hA5) begin
      errors++;
      $display("FAIL fwft_pop: got E=%b rd0=%h want 1 a5", empty1, rd_data0);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom), 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 1, DW'($urandom), 1);
      checks++;
      if (wc0 !== 5'd5 || rd_data0 !== m_rd0 || rd_data1 !== q[0]) begin
        errors++;
        $display("FAIL b2b_%0d: got cnt=%0d rd0=%h rd1=%h want 5 %h %h",
                 i, wc0, rd_data0, rd_data1, m_rd0, q[0]);
      end
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(0, 1, 8'h5A, 1);
    checks++;
    if (wc0 !== 5'd1 || unf0 !== 1'b1 || ovf0 !== 1'b0 || rd_data1 !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_at_empty: got cnt=%0d UNF=%b OVF=%b rd1=%h want 1 1 0 5a",
               wc0, unf0, ovf0, rd_data1);
    end
    while (q.size() < DEPTH) step(0, 1, DW'($urandom), 0);
    step(0, 1, 8'h77, 1);
    checks++;
    if (wc0 !== 5'd15 || ovf0 !== 1'b1 || unf0 !== 1'b0 || rd_data0 !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_at_full: got cnt=%0d OVF=%b UNF=%b rd0=%h want 15 1 0 5a",
               wc0, ovf0, unf0, rd_data0);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, DW'(8'h30 + i), 0);
    checks++;
    if (wc0 !== 5'd9) begin
      errors++;
      $display("FAIL mid_pre_count: got %0d want 9", wc0);
    end
    step(1, 1, 8'hFF, 1);
    checks++;
    if (wc0 !== 5'd0 || empty0 !== 1'b1 || empty1 !== 1'b1 || rd_data0 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%0d E0=%b E1=%b rd0=%h want 0 1 1 00",
               wc0, empty0, empty1, rd_data0);
    end
    step(0, 1, 8'hC3, 0);
    checks++;
    if (rd_data1 !== 8'hC3 || wc0 !== 5'd1) begin
      errors++;
      $display("FAIL mid_new_head: got rd1=%h cnt=%0d want c3 1", rd_data1, wc0);
    end
    step(0, 0, 0, 1);
    checks++;
    if (rd_data0 !== 8'hC3 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_new_data: got rd0=%h E=%b want c3 1", rd_data0, empty0);
    end
  endtask

  task automatic test_random();
    int n, wp, rp;
    logic [7:0] exp_flags;
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      step(0, $urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
      n = q.size();
      exp_flags = {n == 0, n == DEPTH, n <= 1, n >= DEPTH - 1, n <= PE, n >= PF, m_ovf, m_unf};
      checks++;
      if (wc0 !== 5'(n) || {empty0, full0, ae0, af0, pe0, pf0, ovf0, unf0} !== exp_flags) begin
        errors++;
        $display("FAIL rand_std_%0d: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, wc0,
                 {empty0, full0, ae0, af0, pe0, pf0, ovf0, unf0}, n, exp_flags);
      end
      checks++;
      if (wc1 !== 5'(n) || {empty1, full1, ae1, af1, pe1, pf1, ovf1, unf1} !== exp_flags) begin
        errors++;
        $display("FAIL rand_fwft_%0d: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, wc1,
                 {empty1, full1, ae1, af1, pe1, pf1, ovf1, unf1}, n, exp_flags);
      end
      checks++;
      if (rd_data0 !== m_rd0) begin
        errors++;
        $display("FAIL rand_rd0_%0d: got %h want %h", i, rd_data0, m_rd0);
      end
      if (n != 0) begin
        checks++;
        if (rd_data1 !== q[0]) begin
          errors++;
          $display("FAIL rand_rd1_%0d: got %h want %h", i, rd_data1, q[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_rd0 = '0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
